// File: rtl/instruction_fetch_pkg.sv
// Instruction fetch package: widths, state enum, buffer entry.
// Imported by instruction_fetch and fetch_buffer.
`include "config.inc.v"

package instruction_fetch_pkg;

  localparam int ADDR_W = `IMEM_ADDR_WIDTH;
  localparam int DATA_W = `IMEM_DATA_WIDTH;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    BOOT  = `FSM_BOOT,
    RUN   = `FSM_RUN,
    FLUSH = `FSM_FLUSH
  } fetch_state_t;

  typedef struct packed {
    data_t instr;
    addr_t pc;
  } fetch_entry_t;

endpackage

// File: rtl/config.inc.v
// Fetch-unit configuration: memory widths and FSM state codes.
// Shared by every file of the fetch unit.
`ifndef CONFIG_INC_V
`define CONFIG_INC_V

`define IMEM_ADDR_WIDTH 8
`define IMEM_DATA_WIDTH 32

`define FSM_BOOT  2'd0
`define FSM_RUN   2'd1
`define FSM_FLUSH 2'd2

`endif

// File: rtl/fetch_buffer.sv
// Fetched-instruction FIFO with flush, push, pop and occupancy.
// Ports: clk, rst, flush, push/push_entry, pop, head, count.
`include "config.inc.v"

module fetch_buffer
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic          full;

  assign full    = (count == DEPTH[PW:0]);
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst)
      mem[wr_ptr] <= push_entry;
  end

  // Empty buffer presents zeros so the outputs are defined.
  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC sequencing, redirect flush, imem requests.
// Ports: clk, rst, imem_req/addr/data, redirect, instr handshake.
`include "config.inc.v"

module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter addr_t RESET_PC  = '0,
  parameter int    BUF_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req,
  output logic [`IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic [`IMEM_DATA_WIDTH-1:0] imem_data,
  input  logic                        redirect,
  input  logic [`IMEM_ADDR_WIDTH-1:0] redirect_addr,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [`IMEM_DATA_WIDTH-1:0] instr,
  output logic [`IMEM_ADDR_WIDTH-1:0] instr_pc
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t  state;
  addr_t         pc;
  addr_t         inflight_pc;
  logic          inflight;
  logic          issue;
  logic          push;
  logic          pop;
  logic [CW-1:0] count;
  logic [CW:0]   demand;
  fetch_entry_t  head;
  fetch_entry_t  resp;

  assign instr_valid = (count != '0) && !rst;
  assign pop         = instr_valid && instr_ready;

  // Slots already claimed once this cycle's pop retires.
  assign demand = {1'b0, count}
                + {{CW{1'b0}}, inflight}
                - {{CW{1'b0}}, pop};

  assign issue = (state == RUN) && !redirect && !rst
              && (demand < BUF_DEPTH[CW:0]);

  // A redirect kills the response arriving this cycle.
  assign push = inflight && !redirect;

  assign resp      = '{instr: imem_data, pc: inflight_pc};
  assign imem_req  = issue;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= pc;

      if (redirect)   pc <= redirect_addr;
      else if (issue) pc <= pc + addr_t'(1);

      unique case (state)
        BOOT:    state <= redirect ? FLUSH : RUN;
        RUN:     state <= redirect ? FLUSH : RUN;
        FLUSH:   state <= redirect ? FLUSH : RUN;
        default: state <= BOOT;
      endcase
    end
  end

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_entry(resp),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign instr    = instr_valid ? head.instr : '0;
  assign instr_pc = instr_valid ? head.pc    : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch.
// Memory model, expected-PC queue, directed and random phases.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam addr_t RST_PC = '0;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  imem_req;
  addr_t imem_addr;
  data_t imem_data = '0;
  logic  redirect = 1'b0;
  addr_t redirect_addr = '0;
  logic  instr_valid;
  logic  instr_ready = 1'b0;
  data_t instr;
  addr_t instr_pc;

  instruction_fetch #(
    .RESET_PC (RST_PC),
    .BUF_DEPTH(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .instr_pc     (instr_pc)
  );

  always #5 clk = ~clk;

  function automatic data_t mem_word(input addr_t a);
    return data_t'({8'hA5, a, ~a, a ^ addr_t'(8'h3C)});
  endfunction

  always @(posedge clk)
    imem_data <= imem_req ? mem_word(imem_addr) : data_t'(32'hDEAD_BEEF);

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag,
                          input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  addr_t exp_q[$];
  addr_t gen_pc;
  addr_t exp_req_addr;
  addr_t exp_pc;
  int    n_xfer = 0;

  function automatic void refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back(gen_pc);
      gen_pc = gen_pc + addr_t'(1);
    end
  endfunction

  function automatic void restart(input addr_t a);
    exp_q.delete();
    gen_pc       = a;
    exp_req_addr = a;
    refill();
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      check_eq("rst_valid", 32'(instr_valid), 0);
      check_eq("rst_req", 32'(imem_req), 0);
      check_eq("rst_instr", instr, 0);
      check_eq("rst_instr_pc", 32'(instr_pc), 0);
      restart(RST_PC);
    end else begin
      if (redirect)
        check_eq("req_on_redirect", 32'(imem_req), 0);
      if (imem_req) begin
        check_eq("req_addr", 32'(imem_addr), 32'(exp_req_addr));
        exp_req_addr = exp_req_addr + addr_t'(1);
      end
      if (instr_valid && instr_ready) begin
        exp_pc = exp_q.pop_front();
        refill();
        check_eq("xfer_pc", 32'(instr_pc), 32'(exp_pc));
        check_eq("xfer_instr", instr, mem_word(exp_pc));
        n_xfer++;
      end
      // The transfer above still belongs to the old stream.
      if (redirect) restart(redirect_addr);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called in the BOOT or FLUSH cycle; that cycle counts as 0.
  task automatic wait_first(input string tag, input addr_t pc_exp);
    int lat;
    lat = 0;
    @(negedge clk);
    check_eq({tag, "_gap_valid"}, 32'(instr_valid), 0);
    check_eq({tag, "_gap_req"}, 32'(imem_req), 0);
    while (!instr_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, lat, 3);
    check_eq({tag, "_pc"}, 32'(instr_pc), 32'(pc_exp));
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input addr_t a);
    redirect      = 1'b1;
    redirect_addr = a;
    step(1);
    redirect      = 1'b0;
  endtask

  initial begin
    addr_t held_pc;
    data_t held_instr;
    int    base;

    rst         = 1'b1;
    instr_ready = 1'b1;
    step(3);
    rst = 1'b0;
    wait_first("boot", RST_PC);

    base = n_xfer;
    step(10);
    check_eq("throughput", n_xfer - base, 10);

    instr_ready = 1'b0;
    @(negedge clk);
    held_pc    = instr_pc;
    held_instr = instr;
    repeat (5) begin
      @(negedge clk);
      check_eq("stall_valid", 32'(instr_valid), 1);
      check_eq("stall_pc", 32'(instr_pc), 32'(held_pc));
      check_eq("stall_instr", instr, held_instr);
    end
    check_eq("stall_req", 32'(imem_req), 0);
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    step(6);

    // Entry buffered and one in flight, none may appear.
    instr_ready = 1'b0;
    do_redirect(addr_t'(8'h40));
    instr_ready = 1'b1;
    wait_first("redir40", addr_t'(8'h40));
    step(4);

    do_redirect(addr_t'(8'h80));
    wait_first("redir80", addr_t'(8'h80));
    step(3);

    redirect      = 1'b1;
    redirect_addr = addr_t'(8'h10);
    step(1);
    do_redirect(addr_t'(8'h20));
    wait_first("redir_twice", addr_t'(8'h20));
    step(3);

    do_redirect(addr_t'(8'hFD));
    wait_first("wrap", addr_t'(8'hFD));
    base = n_xfer;
    step(8);
    check_eq("wrap_xfers", n_xfer - base, 8);

    instr_ready = 1'b0;
    step(4);
    @(negedge clk);
    check_eq("full_valid", 32'(instr_valid), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1);
    rst         = 1'b0;
    instr_ready = 1'b1;
    wait_first("rst_mid", RST_PC);

    repeat (300) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        redirect      = 1'b1;
        redirect_addr = addr_t'($urandom);
      end else begin
        redirect = 1'b0;
      end
      step(1);
    end
    redirect    = 1'b0;
    instr_ready = 1'b1;
    step(10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
